switch_debouncer: RTL and testbench

//   Conditions the raw slide-switch pins before the switch PIO's in_port.
//   Per bit: 2-FF synchroniser, then a debounce counter that accepts a new

---
 rtl/sw_cond_pkg.sv | 25 ++
 rtl/debounce_bit.sv | 65 ++++++
 rtl/switch_debouncer.sv | 43 ++++
 tb/tb_switch_debouncer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sw_cond_pkg.sv
// Shared constants and elaboration helpers for the slide-switch conditioning path.
// Imported by the per-bit debouncer and the switch_debouncer top level.
package sw_cond_pkg;

    localparam int SW_WIDTH                = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;   // 10 ms at 50 MHz

    // Edge classification of an accepted level change.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_kind_e;

    // Number of bits needed to hold values 0 .. value-1 (minimum 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-FF synchroniser, steady-level counter, accepted level and
// registered one-cycle rise/fall pulses.
module debounce_bit
    import sw_cond_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    localparam int CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall,
    output logic accept
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             stable_next;
    edge_kind_e       edge_next;

    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        cnt_next    = '0;
        stable_next = sw_stable;
        edge_next   = EDGE_NONE;
        if (s2 != sw_stable) begin
            if (cnt == CNT_LAST) begin
                stable_next = s2;
                edge_next   = s2 ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    assign accept = (edge_next != EDGE_NONE);

    // NOTE: sequential state uses non-blocking assignments so s1 -> s2 shifts
    // by one stage per clock regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            cnt       <= '0;
            sw_stable <= 1'b0;
            sw_rise   <= 1'b0;
            sw_fall   <= 1'b0;
        end else begin
            s1        <= sw_raw;
            s2        <= s1;
            cnt       <= cnt_next;
            sw_stable <= stable_next;
            sw_rise   <= (edge_next == EDGE_RISE);
            sw_fall   <= (edge_next == EDGE_FALL);
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a vector of slide-switch pins for the switch PIO in_port and
// reports per-bit rise/fall pulses plus a combined change pulse.
module switch_debouncer
    import sw_cond_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    logic [WIDTH-1:0] accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .sw_raw    (sw_raw[i]),
            .sw_stable (sw_stable[i]),
            .sw_rise   (sw_rise[i]),
            .sw_fall   (sw_fall[i]),
            .accept    (accept[i])
        );
    end

    // Registered from the same pre-edge acceptance as rise/fall, so it lines up with them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |accept;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios plus random pin
// activity, compared against a windowed history model (N=4 and N=1 instances).
module tb_switch_debouncer;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] sw_raw;

    logic [W-1:0] stable4, rise4, fall4;
    logic         chg4;
    logic [W-1:0] stable1, rise1, fall1;
    logic         chg1;

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_raw     (sw_raw),
        .sw_stable  (stable4),
        .sw_rise    (rise4),
        .sw_fall    (fall4),
        .sw_changed (chg4)
    );

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) u_dut_n1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_raw     (sw_raw),
        .sw_stable  (stable1),
        .sw_rise    (rise1),
        .sw_fall    (fall1),
        .sw_changed (chg1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw pin history per edge; a level is accepted when the
    // synchronised value differed from the accepted level on the last N edges,
    // all of them after the previous acceptance or reset.
    localparam int HIST = 8192;
    logic [W-1:0] samp [HIST];
    logic [W-1:0] s2h  [HIST];
    int           t  = 0;
    int           t0 = 1;
    int           nn [2] = '{4, 1};
    int           last_acc [2][W];
    logic [W-1:0] m_st [2];
    logic [W-1:0] m_rise [2];
    logic [W-1:0] m_fall [2];

    // Observation bookkeeping for directed timing checks.
    int           t_chg4, t_chg1;
    logic [W-1:0] rise_at_chg;
    int           rise5_cnt, fall_cnt;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, t);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m]   = '0;
            m_rise[m] = '0;
            m_fall[m] = '0;
            for (int i = 0; i < W; i++) last_acc[m][i] = t;
        end
        t0 = t + 1;
    endtask

    task automatic model_edge();
        logic ok;
        t++;
        samp[t] = sw_raw;
        s2h[t]  = (t - 2 >= t0) ? samp[t-2] : '0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            m_rise[m] = '0;
            m_fall[m] = '0;
            for (int i = 0; i < W; i++) begin
                if (t - last_acc[m][i] >= nn[m]) begin
                    ok = 1'b1;
                    for (int k = 0; k < nn[m]; k++)
                        if (s2h[t-k][i] == m_st[m][i]) ok = 1'b0;
                    if (ok) begin
                        m_st[m][i]   = ~m_st[m][i];
                        m_rise[m][i] = m_st[m][i];
                        m_fall[m][i] = ~m_st[m][i];
                        last_acc[m][i] = t;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("stable_n4",  stable4, m_st[0]);
        check("rise_n4",    rise4,   m_rise[0]);
        check("fall_n4",    fall4,   m_fall[0]);
        check("changed_n4", W'(chg4), W'(|(m_rise[0] | m_fall[0])));
        check("stable_n1",  stable1, m_st[1]);
        check("rise_n1",    rise1,   m_rise[1]);
        check("fall_n1",    fall1,   m_fall[1]);
        check("changed_n1", W'(chg1), W'(|(m_rise[1] | m_fall[1])));
        if (chg4 && t_chg4 < 0) begin
            t_chg4      = t;
            rise_at_chg = rise4;
        end
        if (chg1 && t_chg1 < 0) t_chg1 = t;
        rise5_cnt += int'(rise4[5]);
        fall_cnt  += int'(fall4 != '0);
    endtask

    // Inputs change 1 time unit after the active edge; outputs sampled 1 unit after it.
    task automatic step(input logic [W-1:0] v);
        sw_raw = v;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic clear_obs();
        t_chg4      = -1;
        t_chg1      = -1;
        rise_at_chg = '0;
        rise5_cnt   = 0;
        fall_cnt    = 0;
    endtask

    task automatic async_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_stable",  stable4, '0);
        check("async_rst_rise",    rise4,   '0);
        check("async_rst_fall",    fall4,   '0);
        check("async_rst_changed", W'(chg4), '0);
    endtask

    initial begin
        int           t_start;
        logic [W-1:0] cur;

        // 1: reset with all pins high, then release.
        reset_n = 1'b1;
        sw_raw  = '1;
        clear_obs();
        async_reset();
        hold('1, 3);
        reset_n = 1'b1;
        t_start = t + 1;
        clear_obs();
        hold('1, 8);
        check("t1_latency_n4", W'(t_chg4 - t_start), W'(5));
        check("t1_rise_vec",   rise_at_chg, '1);
        check("t1_latency_n1", W'(t_chg1 - t_start), W'(2));

        // 2: bit 0 rise then fall, from an all-low accepted state.
        hold('0, 8);
        clear_obs();
        t_start = t + 1;
        hold(10'h001, 8);
        check("t2_rise_latency", W'(t_chg4 - t_start), W'(5));
        check("t2_n1_latency",   W'(t_chg1 - t_start), W'(2));
        clear_obs();
        t_start = t + 1;
        hold(10'h000, 8);
        check("t2_fall_latency", W'(t_chg4 - t_start), W'(5));
        check("t2_fall_count",   W'(fall_cnt), W'(1));

        // 3: glitch on bit 3 rejected, long pulse accepted.
        clear_obs();
        hold(10'h008, 3);
        hold(10'h000, 8);
        check("t3_glitch_no_change", W'(t_chg4 >= 0), '0);
        clear_obs();
        hold(10'h008, 5);
        hold(10'h000, 10);
        check("t3_long_accepted", W'(t_chg4 >= 0), W'(1));

        // 4: bounce on bit 5 settling high.
        clear_obs();
        step(10'h020); step(10'h000); step(10'h020);
        step(10'h020); step(10'h000);
        t_start = t + 1;
        hold(10'h020, 9);
        check("t4_single_rise", W'(rise5_cnt), W'(1));
        check("t4_no_fall",     W'(fall_cnt),  '0);
        check("t4_latency",     W'(t_chg4 - t_start), W'(5));
        hold(10'h000, 8);

        // 5: simultaneous change on several bits.
        clear_obs();
        hold(10'h2A5, 8);
        check("t5_rise_vec", rise_at_chg, 10'h2A5);
        hold(10'h000, 8);

        // 6: reset while bit 9 is mid-count, pin stays high.
        clear_obs();
        hold(10'h200, 4);
        async_reset();
        hold(10'h200, 2);
        reset_n = 1'b1;
        clear_obs();
        t_start = t + 1;
        hold(10'h200, 8);
        check("t6_latency", W'(t_chg4 - t_start), W'(5));

        // Random pin activity with occasional asynchronous resets.
        cur = sw_raw;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(5) == 0) cur[i] = ~cur[i];
            if ($urandom_range(149) == 0) begin
                async_reset();
                step(cur);
                reset_n = 1'b1;
            end
            step(cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
